// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
// Shared types and constants for the instruction-buffer loader.
//   state_t         : loader FSM states
//   CHECKSUM_WIDTH  : width of the running XOR checksum
//   bytes_per_word  : host bytes needed to fill one buffer word (rounded up)
// -----------------------------------------------------------------------------
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        WRITE   = 3'd2,
        CHECK   = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam int CHECKSUM_WIDTH = 8;

    function automatic int bytes_per_word(input int word_width, input int byte_width);
        return (word_width + byte_width - 1) / byte_width;
    endfunction

endpackage

// File: rtl/imem_byte_packer.sv
// -----------------------------------------------------------------------------
// imem_byte_packer
// Packs a little-endian byte stream into W-bit buffer words. Byte k lands in
// bits [k*BW +: BW]; bits of the last byte beyond W are dropped. The finished
// word is copied to o_word when its last byte arrives, so o_word holds its
// value while the next word is being assembled.
// Ports:
//   clk, reset   : clock, asynchronous active-low reset
//   i_clear      : restart packing at byte 0 (new load)
//   i_accept     : a byte is consumed this cycle
//   i_data       : byte value
//   o_word       : last completed word
//   o_word_full  : the byte accepted this cycle completes a word
// -----------------------------------------------------------------------------
module imem_byte_packer
    import imem_loader_pkg::*;
#(
    parameter int W  = 40,
    parameter int BW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_clear,
    input  logic          i_accept,
    input  logic [BW-1:0] i_data,
    output logic [W-1:0]  o_word,
    output logic          o_word_full
);

    localparam int NB    = bytes_per_word(W, BW);
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam int ACC_W = NB * BW;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

    logic [IDX_W-1:0] r_idx;
    logic [ACC_W-1:0] r_acc;
    logic [W-1:0]     r_word;
    logic [ACC_W-1:0] w_acc_next;

    // NOTE: assign the default first so every path writes w_acc_next and no latch is inferred.
    always_comb begin
        w_acc_next = r_acc;
        w_acc_next[r_idx*BW +: BW] = i_data;
    end

    assign o_word_full = i_accept && (r_idx == LAST_IDX);
    assign o_word      = r_word;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idx  <= '0;
            r_acc  <= '0;
            r_word <= '0;
        end else if (i_clear) begin
            r_idx <= '0;
            r_acc <= '0;
        end else if (i_accept) begin
            if (r_idx == LAST_IDX) begin
                r_idx  <= '0;
                r_acc  <= '0;
                r_word <= w_acc_next[W-1:0];
            end else begin
                r_idx <= r_idx + 1'b1;
                r_acc <= w_acc_next;
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Host-side controller that programs the PAT instruction buffer. A byte stream
// (valid/ready) is packed into W = i_buffer_size*i_width bit words, each written
// at base + count*i_buffer_size (wrapping at 2^i_adr_width). The PAT is held in
// reset (pat_run low) until the load completes.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR
// checksum byte after the last word; a mismatch raises load_error and keeps
// pat_run low. Without it, load_error is tied to 0 and DONE follows the last
// write directly.
// Ports:
//   clk, reset                : clock, asynchronous active-low reset
//   load_start, load_base/len : start pulse, first address, word count
//   in_data, in_valid, in_ready : host byte stream
//   imem_write_adr/write/in   : instruction-buffer write port
//   busy, pat_run, load_error : status
// -----------------------------------------------------------------------------
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int  i_adr_width   = 10,
    parameter int  i_width       = 20,
    parameter int  i_buffer_size = 2,
    parameter int  byte_width    = 8,
    localparam int W             = i_buffer_size * i_width
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load_start,
    input  logic [i_adr_width-1:0] load_base,
    input  logic [i_adr_width-1:0] load_len,
    input  logic [byte_width-1:0]  in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [i_adr_width-1:0] imem_write_adr,
    output logic                   imem_write,
    output logic [W-1:0]           imem_in,
    output logic                   busy,
    output logic                   pat_run,
    output logic                   load_error
);

    localparam logic [i_adr_width-1:0] ADR_STEP = i_adr_width'(i_buffer_size);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t NO_MORE_WORDS = CHECK;
`else
    localparam state_t NO_MORE_WORDS = DONE;
`endif

    state_t                 r_state;
    state_t                 w_state_next;
    logic [i_adr_width-1:0] r_base;
    logic [i_adr_width-1:0] r_len;
    logic [i_adr_width-1:0] r_count;
    logic [i_adr_width-1:0] r_adr;
    logic [i_adr_width-1:0] w_count_inc;
    logic                   r_pat_run;
    logic                   w_pat_next;
    logic                   w_start;
    logic                   w_accept;
    logic                   w_collect_acc;
    logic                   w_word_full;
    logic                   w_err_next;

    // load_start is honoured only while no load is in progress.
    assign w_start       = load_start && ((r_state == IDLE) || (r_state == DONE));
    assign w_accept      = in_valid && in_ready;
    assign w_collect_acc = w_accept && (r_state == COLLECT);
    assign w_count_inc   = r_count + 1'b1;

    assign in_ready       = (r_state == COLLECT) || (r_state == CHECK);
    assign imem_write     = (r_state == WRITE);
    assign busy           = (r_state == COLLECT) || (r_state == WRITE) || (r_state == CHECK);
    assign imem_write_adr = r_adr;
    assign pat_run        = r_pat_run;

    imem_byte_packer #(
        .W  (W),
        .BW (byte_width)
    ) u_packer (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (w_start),
        .i_accept    (w_collect_acc),
        .i_data      (in_data),
        .o_word      (imem_in),
        .o_word_full (w_word_full)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [CHECKSUM_WIDTH-1:0] r_csum;
    logic [CHECKSUM_WIDTH-1:0] w_byte_ext;
    logic                      r_load_error;

    assign w_byte_ext = CHECKSUM_WIDTH'(in_data);
    assign load_error = r_load_error;

    always_comb begin
        w_err_next = r_load_error;
        if (w_start) begin
            w_err_next = 1'b0;
        end else if ((r_state == CHECK) && w_accept && (w_byte_ext != r_csum)) begin
            w_err_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_csum       <= '0;
            r_load_error <= 1'b0;
        end else begin
            r_load_error <= w_err_next;
            if (w_start) begin
                r_csum <= '0;
            end else if (w_collect_acc) begin
                r_csum <= r_csum ^ w_byte_ext;
            end
        end
    end
`else
    assign w_err_next = 1'b0;
    assign load_error = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (w_start) begin
                    w_state_next = (load_len == '0) ? NO_MORE_WORDS : COLLECT;
                end
            end
            COLLECT: begin
                if (w_word_full) begin
                    w_state_next = WRITE;
                end
            end
            WRITE: begin
                w_state_next = (w_count_inc == r_len) ? NO_MORE_WORDS : COLLECT;
            end
            CHECK: begin
                if (w_accept) begin
                    w_state_next = DONE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // pat_run is registered alongside the state so it rises on DONE entry; a
    // new start forces one low cycle even when the next state is DONE again.
    assign w_pat_next = (w_state_next == DONE) && !w_start && !w_err_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_base    <= '0;
            r_len     <= '0;
            r_count   <= '0;
            r_adr     <= '0;
            r_pat_run <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_pat_run <= w_pat_next;
            if (w_start) begin
                r_base  <= load_base;
                r_len   <= load_len;
                r_count <= '0;
            end
            // Address is set up as the word completes so it is valid with the strobe.
            if (w_word_full) begin
                r_adr <= r_base + r_count * ADR_STEP;
            end
            if (r_state == WRITE) begin
                r_count <= w_count_inc;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
// Directed bench for imem_loader: basic load, address wrap, gapped input,
// ignored mid-load start, reset mid-load, zero-length load and (when
// IMEM_LOADER_CHECKSUM_EN is defined) checksum pass/fail.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_imem_loader;

    localparam int AW = 10;
    localparam int IW = 20;
    localparam int BS = 2;
    localparam int BW = 8;
    localparam int W  = BS * IW;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam int CS_EXTRA = 1;
`else
    localparam int CS_EXTRA = 0;
`endif

    logic          clk        = 1'b0;
    logic          reset      = 1'b1;
    logic          load_start = 1'b0;
    logic [AW-1:0] load_base  = '0;
    logic [AW-1:0] load_len   = '0;
    logic [BW-1:0] in_data    = '0;
    logic          in_valid   = 1'b0;
    logic          in_ready;
    logic [AW-1:0] imem_write_adr;
    logic          imem_write;
    logic [W-1:0]  imem_in;
    logic          busy;
    logic          pat_run;
    logic          load_error;

    imem_loader #(
        .i_adr_width   (AW),
        .i_width       (IW),
        .i_buffer_size (BS),
        .byte_width    (BW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .load_start     (load_start),
        .load_base      (load_base),
        .load_len       (load_len),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .imem_write_adr (imem_write_adr),
        .imem_write     (imem_write),
        .imem_in        (imem_in),
        .busy           (busy),
        .pat_run        (pat_run),
        .load_error     (load_error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_acc_cyc = 0;
    int n_acc    = 0;

    logic [AW-1:0] wr_adr_q[$];
    logic [W-1:0]  wr_dat_q[$];
    int            wr_lat_q[$];

    int gaps [10] = '{0, 2, 0, 1, 3, 0, 0, 4, 1, 2};

    always @(posedge clk) cyc++;

    // Observe the write port and the handshake mid-cycle, away from the edge.
    always @(negedge clk) begin
        if (imem_write) begin
            wr_adr_q.push_back(imem_write_adr);
            wr_dat_q.push_back(imem_in);
            wr_lat_q.push_back(cyc - last_acc_cyc);
        end
        if (in_valid && in_ready) begin
            n_acc++;
            last_acc_cyc = cyc;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        wr_adr_q.delete();
        wr_dat_q.delete();
        wr_lat_q.delete();
        n_acc = 0;
    endtask

    task automatic start_load(input logic [AW-1:0] base, input logic [AW-1:0] len);
        load_base  = base;
        load_len   = len;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    // Present one byte after 'gap' idle cycles and hold it until accepted.
    task automatic send_byte(input logic [BW-1:0] b, input int gap);
        int n;
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) tick();
        end
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("send_timeout", {63'b0, in_ready}, 64'd1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_seq(input logic [BW-1:0] first, input int count, input bit gapped);
        for (int i = 0; i < count; i++) begin
            send_byte(first + BW'(i), gapped ? gaps[i % 10] : 0);
        end
    endtask

    function automatic logic [7:0] xor_seq(input logic [7:0] first, input int count);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < count; i++) x = x ^ (first + 8'(i));
        return x;
    endfunction

    // Send the trailing checksum byte when the checksum feature is built in.
    task automatic finish_load(input logic [7:0] csum);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(csum, 0);
`else
        in_data = csum;
`endif
    endtask

    task automatic check_write(input string tag, input int idx,
                               input logic [AW-1:0] adr, input logic [W-1:0] dat);
        if (idx < wr_adr_q.size()) begin
            check({tag, "_adr"}, 64'(wr_adr_q[idx]), 64'(adr));
            check({tag, "_dat"}, 64'(wr_dat_q[idx]), 64'(dat));
            check({tag, "_lat"}, 64'(wr_lat_q[idx]), 64'd1);
        end else begin
            check({tag, "_missing"}, 64'(wr_adr_q.size()), 64'(idx + 1));
        end
    endtask

    initial begin
        // ---------------- reset state ----------------
        #3 reset = 1'b0;
        repeat (2) tick();
        check("rst_in_ready",  64'(in_ready),       64'd0);
        check("rst_write",     64'(imem_write),     64'd0);
        check("rst_adr",       64'(imem_write_adr), 64'd0);
        check("rst_imem_in",   64'(imem_in),        64'd0);
        check("rst_busy",      64'(busy),           64'd0);
        check("rst_pat_run",   64'(pat_run),        64'd0);
        check("rst_load_err",  64'(load_error),     64'd0);
        reset = 1'b1;
        tick();

        // ---------------- basic load ----------------
        clear_mon();
        start_load(10'h010, 10'd2);
        check("basic_busy", 64'(busy), 64'd1);
        check("basic_pat_low", 64'(pat_run), 64'd0);
        send_seq(8'h01, 10, 1'b0);
        check("basic_strobe", 64'(imem_write), 64'd1);
        check("basic_pat_during_wr", 64'(pat_run), 64'd0);
        tick();
`ifdef IMEM_LOADER_CHECKSUM_EN
        check("basic_pat_wait_cs", 64'(pat_run), 64'd0);
`endif
        finish_load(xor_seq(8'h01, 10));
        check("basic_pat_run", 64'(pat_run), 64'd1);
        check("basic_busy_done", 64'(busy), 64'd0);
        repeat (3) tick();
        check("basic_nwrites", 64'(wr_adr_q.size()), 64'd2);
        check_write("basic_w0", 0, 10'h010, 40'h0504030201);
        check_write("basic_w1", 1, 10'h012, 40'h0A09080706);
        check("basic_hold_adr", 64'(imem_write_adr), 64'h012);
        check("basic_hold_dat", 64'(imem_in), 64'h0A09080706);
        check("basic_nacc", 64'(n_acc), 64'(10 + CS_EXTRA));

        // ---------------- address wrap (started from DONE) ----------------
        clear_mon();
        start_load(10'h3FE, 10'd2);
        check("wrap_pat_drop", 64'(pat_run), 64'd0);
        send_seq(8'h11, 10, 1'b0);
        finish_load(xor_seq(8'h11, 10));
        repeat (3) tick();
        check("wrap_nwrites", 64'(wr_adr_q.size()), 64'd2);
        check_write("wrap_w0", 0, 10'h3FE, 40'h1514131211);
        check_write("wrap_w1", 1, 10'h000, 40'h1A19181716);
        check("wrap_pat_run", 64'(pat_run), 64'd1);

        // ---------------- backpressure and gaps ----------------
        clear_mon();
        start_load(10'h010, 10'd2);
        send_seq(8'h01, 10, 1'b1);
        finish_load(xor_seq(8'h01, 10));
        repeat (3) tick();
        check("gap_nwrites", 64'(wr_adr_q.size()), 64'd2);
        check_write("gap_w0", 0, 10'h010, 40'h0504030201);
        check_write("gap_w1", 1, 10'h012, 40'h0A09080706);
        check("gap_nacc", 64'(n_acc), 64'(10 + CS_EXTRA));

        // ---------------- load_start mid-COLLECT is ignored ----------------
        clear_mon();
        start_load(10'h100, 10'd2);
        send_seq(8'h21, 2, 1'b0);
        start_load(10'h200, 10'd1);
        send_seq(8'h23, 8, 1'b0);
        finish_load(xor_seq(8'h21, 10));
        repeat (3) tick();
        check("ign_nwrites", 64'(wr_adr_q.size()), 64'd2);
        check_write("ign_w0", 0, 10'h100, 40'h2524232221);
        check_write("ign_w1", 1, 10'h102, 40'h2A29282726);

        // ---------------- reset mid-load ----------------
        clear_mon();
        start_load(10'h020, 10'd2);
        send_seq(8'h31, 3, 1'b0);
        in_data  = 8'h34;
        in_valid = 1'b1;
        reset    = 1'b0;
        #1;
        check("mrst_in_ready", 64'(in_ready),       64'd0);
        check("mrst_write",    64'(imem_write),     64'd0);
        check("mrst_adr",      64'(imem_write_adr), 64'd0);
        check("mrst_imem_in",  64'(imem_in),        64'd0);
        check("mrst_busy",     64'(busy),           64'd0);
        check("mrst_pat_run",  64'(pat_run),        64'd0);
        check("mrst_load_err", 64'(load_error),     64'd0);
        repeat (2) tick();
        reset = 1'b1;
        clear_mon();
        repeat (20) tick();
        in_valid = 1'b0;
        check("mrst_no_write", 64'(wr_adr_q.size()), 64'd0);
        check("mrst_no_accept", 64'(n_acc), 64'd0);
        check("mrst_idle_busy", 64'(busy), 64'd0);

        // ---------------- zero length from IDLE ----------------
        clear_mon();
        start_load(10'h050, 10'd0);
        check("len0_pat_low", 64'(pat_run), 64'd0);
        check("len0_busy", 64'(busy), 64'(CS_EXTRA));
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h00, 0);
`else
        tick();
`endif
        check("len0_pat_run", 64'(pat_run), 64'd1);
        check("len0_load_err", 64'(load_error), 64'd0);
        repeat (3) tick();
        check("len0_no_write", 64'(wr_adr_q.size()), 64'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // ---------------- checksum pass / fail ----------------
        clear_mon();
        start_load(10'h000, 10'd1);
        send_seq(8'h01, 5, 1'b0);
        send_byte(8'h01, 0);
        check("cs_ok_pat_run", 64'(pat_run), 64'd1);
        check("cs_ok_err", 64'(load_error), 64'd0);
        start_load(10'h000, 10'd1);
        send_seq(8'h01, 5, 1'b0);
        send_byte(8'h00, 0);
        repeat (3) tick();
        check("cs_bad_err", 64'(load_error), 64'd1);
        check("cs_bad_pat_run", 64'(pat_run), 64'd0);
        check("cs_bad_busy", 64'(busy), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Host-side controller that sequences instruction-buffer programming for the PAT core.
- Accepts a byte stream over a valid/ready handshake and packs it into instruction-buffer words of i_buffer_size*i_width bits.
- Drives imem_write_adr / imem_write / imem_in with auto-incrementing addresses.
- Holds the PAT in reset (pat_run low) until the load completes.

Parameters:
- i_adr_width, 10, instruction address width (matches PAT pc).
- i_width, 20, instruction width in bits.
- i_buffer_size, 2, instructions per buffer word; word width W = i_buffer_size*i_width = 40.
- byte_width, 8, host byte width; bytes per word NB = ceil(W/byte_width) = 5.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- load_start  in  1  one-cycle pulse; samples load_base and load_len.
- load_base  in  i_adr_width  instruction address of the first word.
- load_len  in  i_adr_width  number of buffer words to load.
- in_data  in  byte_width  host byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts a byte this cycle.
- imem_write_adr  out  i_adr_width  instruction-buffer write address.
- imem_write  out  1  one-cycle write strobe.
- imem_in  out  W  packed write word.
- busy  out  1  high in COLLECT/WRITE/CHECK states.
- pat_run  out  1  high = PAT released from reset.
- load_error  out  1  checksum mismatch flag (sticky until next load_start).

Behaviour:
- Reset (reset=0, async): state IDLE. All outputs are 0: in_ready, imem_write, imem_write_adr, imem_in, busy, pat_run, load_error. Byte index and word count are cleared. Reset mid-load discards any partial word, and no write is issued.
- IDLE/DONE, on load_start:
  - Latch base and len; clear word count, byte index and load_error.
  - Drop pat_run to 0 in the next cycle.
  - Go to COLLECT, or to DONE/CHECK if len==0.
  - load_start in any other state is ignored.
- COLLECT:
  - in_ready=1. A byte is accepted on in_valid&in_ready.
  - Byte k (k=0..NB-1) lands in imem_in bits [k*byte_width +: byte_width], truncated at W; bits beyond W are dropped. Ordering is little-endian.
  - When byte NB-1 is accepted, go to WRITE.
- WRITE (exactly one cycle):
  - imem_write=1, in_ready=0.
  - imem_write_adr = base + count*i_buffer_size, modulo 2^i_adr_width (wraps silently).
  - imem_in is held stable during the strobe.
  - Latency: last byte accepted in cycle N, so imem_write is high in cycle N+1.
  - Then increment count. If count==len, go to CHECK (macro on) or DONE; otherwise go to COLLECT.
- DONE: pat_run=1, busy=0, in_ready=0. Stays in DONE until the next load_start or reset.
- in_valid while in_ready=0: the byte is not consumed, and the host holds it. Idle gaps in in_valid are allowed anywhere.
- imem_write_adr and imem_in retain their last values between writes.

Optional Feature:
- IMEM_LOADER_CHECKSUM_EN defined:
  - An 8-bit running XOR of all accepted data bytes is kept.
  - After the last word, state CHECK sets in_ready=1 and accepts one checksum byte.
  - If the byte equals the running XOR, go to DONE.
  - Otherwise set load_error=1, go to DONE, and keep pat_run=0.
  - For len==0 the expected checksum byte is 0x00.
- IMEM_LOADER_CHECKSUM_EN undefined: no CHECK state, load_error is tied to 0, and DONE follows the last WRITE directly.

Decomposition:
- Package imem_loader_pkg holds:
  - state enum (IDLE, COLLECT, WRITE, CHECK, DONE);
  - localparam function bytes_per_word(W, byte_width);
  - checksum width constant.
- Sub-module imem_byte_packer holds the byte-index counter, the little-endian packing register and the word_full flag. The FSM, address generation and checksum stay in imem_loader.

Test Plan:
- Basic load: base=0x010, len=2, bytes 0x01..0x0A back-to-back. Required: write @0x010 imem_in=0x0504030201, then write @0x012 imem_in=0x0A09080706. pat_run rises after the second write.
- Address wrap: base=0x3FE, len=2. Required: writes at 0x3FE then 0x000.
- Backpressure and gaps: random in_valid gaps. Required: same data and addresses as the basic load, exactly one imem_write per word, and no byte is consumed while in_ready=0.
- Ignored start and zero length:
  - load_start mid-COLLECT has no effect on base or count.
  - len=0 from IDLE goes to DONE with no writes (macro off).
- Reset mid-load: assert reset after 3 bytes of word 0. Required: all outputs 0 at once, and no imem_write after reset releases.
- Checksum (macro on): bytes 0x01..0x05 then checksum 0x01 gives pat_run=1, load_error=0. Sending 0x00 instead gives load_error=1, pat_run=0.
